// File: rtl/line_draw_scheduler.sv
// line_draw_scheduler: queues line commands, launches the line engine, forwards its pixels and sweeps a full-screen clear.
// Latency: a push reaches eng_start 2 cycles later; an engine write reaches vga_plot 1 cycle later; a clear is 19200 back-to-back plots.
// Backpressure: cmd_ready falls while the line queue is full; one clear request is latched, extra requests during a sweep are dropped.
// Optional feature macro LDS_CLIP_EN: off-screen engine writes are dropped and counted on clip_count.
module line_draw_scheduler #(
    parameter int H_RES      = 160,
    parameter int V_RES      = 120,
    parameter int FIFO_DEPTH = 4,
    parameter int COLOUR_W   = 3
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [7:0]          cmd_x0,
    input  logic [7:0]          cmd_x1,
    input  logic [6:0]          cmd_y0,
    input  logic [6:0]          cmd_y1,
    input  logic [COLOUR_W-1:0] cmd_colour,
    input  logic                clear_req,
    input  logic [COLOUR_W-1:0] clear_colour,
    output logic                eng_start,
    output logic [7:0]          eng_x0,
    output logic [7:0]          eng_x1,
    output logic [6:0]          eng_y0,
    output logic [6:0]          eng_y1,
    output logic [COLOUR_W-1:0] eng_colour,
    input  logic                eng_done,
    input  logic                eng_we,
    input  logic [7:0]          eng_x,
    input  logic [6:0]          eng_y,
    output logic                vga_plot,
    output logic [7:0]          vga_x,
    output logic [6:0]          vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                busy
`ifdef LDS_CLIP_EN
    ,
    output logic [7:0]          clip_count
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [7:0] X_LAST = 8'(H_RES - 1);
    localparam logic [6:0] Y_LAST = 7'(V_RES - 1);

    typedef struct packed {
        logic [7:0]          x0;
        logic [6:0]          y0;
        logic [7:0]          x1;
        logic [6:0]          y1;
        logic [COLOUR_W-1:0] colour;
    } line_cmd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        DRAW   = 2'd2,
        CLEAR  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    line_cmd_t        fifo_mem [FIFO_DEPTH];
    line_cmd_t        push_cmd, head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             push, pop, fifo_empty;
    logic             clear_pending;
    logic [COLOUR_W-1:0] clear_colour_q;
    logic [7:0]       cx;
    logic [6:0]       cy;
    logic             clear_last, pix_ok;

    assign push_cmd   = {cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_colour};
    assign head       = fifo_mem[rd_ptr];
    assign cmd_ready  = (fifo_cnt != FULL_CNT);
    assign fifo_empty = (fifo_cnt == '0);
    assign push       = cmd_valid && cmd_ready;
    assign eng_start  = (state_q == LAUNCH);
    assign busy       = (state_q != IDLE) || !fifo_empty || clear_pending;
    assign clear_last = (cx == X_LAST) && (cy == Y_LAST);

`ifdef LDS_CLIP_EN
    assign pix_ok = (eng_x <= X_LAST) && (eng_y <= Y_LAST);
`else
    assign pix_ok = 1'b1;
`endif

    // Command storage: written on accepted pushes, no reset needed for payload.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_cmd;
        end
    end

    // Queue pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a pending clear beats queued lines; the engine handshake sequences each line.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_pending) begin
                    state_d = CLEAR;
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: state_d = DRAW;
            DRAW:   if (eng_done) state_d = IDLE;
            CLEAR:  if (clear_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Launched line parameters, loaded on pop and held for the whole line.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            eng_x0     <= '0;
            eng_y0     <= '0;
            eng_x1     <= '0;
            eng_y1     <= '0;
            eng_colour <= '0;
        end else if (pop) begin
            eng_x0     <= head.x0;
            eng_y0     <= head.y0;
            eng_x1     <= head.x1;
            eng_y1     <= head.y1;
            eng_colour <= head.colour;
        end
    end

    // Clear latch: requests arriving mid-sweep are dropped, the sweep's last pixel retires it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clear_pending  <= 1'b0;
            clear_colour_q <= '0;
        end else if (clear_req && (state_q != CLEAR)) begin
            clear_pending  <= 1'b1;
            clear_colour_q <= clear_colour;
        end else if ((state_q == CLEAR) && clear_last) begin
            clear_pending  <= 1'b0;
        end
    end

    // Raster sweep counters; they end each sweep back at (0,0).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cx <= '0;
            cy <= '0;
        end else if (state_q == CLEAR) begin
            if (cx == X_LAST) begin
                cx <= '0;
                cy <= (cy == Y_LAST) ? 7'd0 : cy + 1'b1;
            end else begin
                cx <= cx + 1'b1;
            end
        end
    end

    // Framebuffer port: one registered write per cycle from the sweep or the engine; coordinates hold when idle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vga_plot   <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
        end else begin
            vga_plot <= 1'b0;
            if (state_q == CLEAR) begin
                vga_plot   <= 1'b1;
                vga_x      <= cx;
                vga_y      <= cy;
                vga_colour <= clear_colour_q;
            end else if ((state_q == DRAW) && eng_we && pix_ok) begin
                vga_plot   <= 1'b1;
                vga_x      <= eng_x;
                vga_y      <= eng_y;
                vga_colour <= eng_colour;
            end
        end
    end

`ifdef LDS_CLIP_EN
    // Saturating count of engine writes that fell outside the screen.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clip_count <= '0;
        end else if ((state_q == DRAW) && eng_we && !pix_ok && (clip_count != 8'hFF)) begin
            clip_count <= clip_count + 1'b1;
        end
    end
`endif

endmodule

// File: doc/line_draw_scheduler.md
Name: line_draw_scheduler

Overview:
Sequences the Bresenham line engine and shares the 160x120 framebuffer write port between line drawing and a full-screen clear.
- Line commands (endpoints plus colour) are queued in a small FIFO.
- Each queued line is launched on the engine with a start/done handshake.
- The engine's pixel writes are forwarded to the VGA adapter RAM port.
- Screen-clear requests are arbitrated with the line queue.
- Sits between the command source (CPU/keyboard FSM) and the Bresenham engine plus VGA adapter.

Parameters:
- H_RES, 160, horizontal pixels; x width fixed at 8.
- V_RES, 120, vertical pixels; y width fixed at 7.
- FIFO_DEPTH, 4, line command queue depth; must be a power of 2, minimum 2.
- COLOUR_W, 3, colour bits per pixel.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  line command offered.
- cmd_ready  out  1  FIFO can accept (= !full).
- cmd_x0, cmd_x1  in  8  line endpoint x coordinates.
- cmd_y0, cmd_y1  in  7  line endpoint y coordinates.
- cmd_colour  in  COLOUR_W  line colour.
- clear_req  in  1  single-cycle clear request pulse.
- clear_colour  in  COLOUR_W  fill colour, sampled with clear_req.
- eng_start  out  1  one-cycle launch pulse to the engine.
- eng_x0, eng_x1  out  8  launched line x endpoints; held stable throughout DRAW.
- eng_y0, eng_y1  out  7  launched line y endpoints; held stable throughout DRAW.
- eng_colour  out  COLOUR_W  launched line colour; held stable throughout DRAW.
- eng_done  in  1  engine finished the current line (one-cycle pulse).
- eng_we  in  1  engine pixel write strobe.
- eng_x  in  8  engine pixel x.
- eng_y  in  7  engine pixel y.
- vga_plot  out  1  framebuffer write enable.
- vga_x  out  8  framebuffer write x.
- vga_y  out  7  framebuffer write y.
- vga_colour  out  COLOUR_W  framebuffer write data.
- busy  out  1  scheduler active: state!=IDLE, or FIFO non-empty, or clear pending.

Behaviour:
Reset (resetn low, asynchronous):
- State IDLE, FIFO empty, clear_pending=0.
- All registered outputs 0: eng_*, vga_*, busy.
- cmd_ready reads 1.
- An operation in progress is abandoned; no further writes occur.

FIFO:
- Push when cmd_valid && cmd_ready.
- Pop only on the IDLE->LAUNCH transition.
- Pointers wrap modulo FIFO_DEPTH; occupancy counter runs 0..FIFO_DEPTH.
- When full, cmd_ready=0 and cmd_valid is ignored.
- A push and a pop in the same cycle are both performed; occupancy is unchanged.

Clear latch:
- clear_req sets clear_pending and captures clear_colour in any state except CLEAR.
- A clear_req during CLEAR is dropped.
- clear_req and a command push in the same cycle are both accepted.

State machine:
- IDLE:
  - If clear_pending, go to CLEAR; clear has priority over queued lines.
  - Else if the FIFO is non-empty, pop the head into the eng_* registers and go to LAUNCH.
  - Else stay in IDLE.
- LAUNCH:
  - eng_start=1 for exactly this cycle, then go to DRAW.
- DRAW:
  - Each cycle with eng_we=1, the next cycle has vga_plot=1 with vga_x/vga_y/vga_colour = eng_x/eng_y/eng_colour. Latency 1, one pixel per cycle, no stalls.
  - On eng_done, go to IDLE. A write strobed in the same cycle as eng_done is still forwarded.
  - A clear request arriving during DRAW waits until the line completes.
- CLEAR:
  - Counters cx, cy start at 0.
  - Each cycle: vga_plot=1, vga_x=cx, vga_y=cy, vga_colour=latched clear colour.
  - cx increments; at H_RES-1 it wraps to 0 and cy increments.
  - After pixel (H_RES-1, V_RES-1): clear clear_pending and go to IDLE. Total H_RES*V_RES = 19200 consecutive plot cycles.

Ignored inputs:
- eng_we and eng_done outside DRAW are ignored; vga_plot=0 and no state change.

Output defaults:
- vga_plot=0 whenever no write is produced.
- vga_x, vga_y and vga_colour hold their last values.

Optional Feature:
Macro: LDS_CLIP_EN
- Defined: in DRAW, engine writes with eng_x>=H_RES or eng_y>=V_RES are suppressed (vga_plot stays 0). Such writes increment an 8-bit saturating clip counter on output port clip_count (out, 8), which resets to 0.
- Undefined: writes are forwarded unchecked; the clip_count port does not exist.

Test Plan:
- Reset mid-DRAW (assert resetn=0 while eng_we toggles) -> next cycle vga_plot=0, eng_start=0, busy=0, cmd_ready=1; after release, no plot until a new command.
- Push (x0=10,y0=5,x1=20,y1=5,c=3) -> eng_start pulses 2 cycles after push (pop, launch) with those values. Engine writes (10..20,5) -> vga_plot each cycle 1 cycle later, colour 3. eng_done -> IDLE, busy=0.
- With the engine stalled in DRAW (no eng_done), push 5 commands -> first launches, next 4 fill the FIFO, cmd_ready=0 (assuming pushes are back-to-back so the first pops before the 5th arrives). After eng_done the next command launches and cmd_ready returns to 1 the cycle after the pop.
- clear_req (colour 5) pulsed during DRAW with 1 line queued -> line completes, then CLEAR runs before the queued line. Exactly 19200 plots; first (0,0), last (159,119), all colour 5. Then the queued line launches.
- clear_req pulsed again during CLEAR -> dropped; exactly 19200 plots, no second sweep.
- LDS_CLIP_EN defined: engine write at (160,0) and at (5,120) -> no vga_plot, clip_count=2. Write at (159,119) -> plotted.
